// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with bubble insertion, stall hold, and HLT
//   detection. Each clock edge applies flush > halted-hold > stall > capture.
//   A captured HLT instruction moves the stage into HALTED, which raises hlt
//   and freezes the stage until a flush kills the HLT or reset is applied.
//   Every output is taken directly from a flop, so there is no combinational
//   path from any input to any output.
//
// Parameters
//   NOP_INSTR    instruction value driven while the stage holds a bubble
//   HLT_OPCODE   opcode (instr[15:12]) that identifies HLT
//
// Ports
//   clk           in   1   sole clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   pc_in         in   16  PC of the instruction being fetched this cycle
//   instr_in      in   16  instruction memory read data for pc_in
//   stall         in   1   hold the stage contents
//   flush         in   1   kill the fetched instruction (branch/jump taken)
//   instr_out     out  16  registered instruction to decode
//   pc_plus1_out  out  16  registered pc_in + 1
//   valid_out     out  1   instr_out is a real, non-squashed instruction
//   hlt           out  1   registered halt request to the program counter
//   stall_cnt     out  8   saturating count of stalled cycles since reset
// -----------------------------------------------------------------------------
module if_id_reg #(
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  input  logic [15:0] instr_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus1_out,
  output logic        valid_out,
  output logic        hlt,
  output logic [7:0]  stall_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q,    state_d;
  logic [15:0] instr_q,    instr_d;
  logic [15:0] pc_plus1_q, pc_plus1_d;
  logic        valid_q,    valid_d;
  logic [7:0]  cnt_q,      cnt_d;

  // Next-state logic for the stage contents and the RUN/HALTED machine.
  always_comb begin
    // NOTE: every signal gets a hold default before any branch so no path
    // leaves a variable unassigned, which would infer a latch.
    state_d    = state_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;

    if (flush) begin
      // Squash into a bubble; the PC link value is deliberately kept.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (state_q == HALTED) begin
      // Frozen: instr_in and stall are ignored until flush or reset.
    end else if (stall) begin
      // Hold everything.
    end else begin
      instr_d    = instr_in;
      pc_plus1_d = pc_in + 16'd1;  // wraps 16'hFFFF to 16'h0000
      valid_d    = 1'b1;
      if (instr_in[15:12] == HLT_OPCODE) begin
        state_d = HALTED;
      end
    end
  end

  // Stall counter counts only real stalls: a halted stage or a flush in the
  // same cycle does not count. It sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN && stall && !flush && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their next-state values from the same edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= 16'h0000;
      valid_q    <= 1'b0;
      cnt_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus1_out = pc_plus1_q;
  assign valid_out    = valid_q;
  assign hlt          = (state_q == HALTED);
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_reg
//   Self-checking bench for if_id_reg. The stimulus process drives directed
//   vectors; after each clock edge a small behavioural model pushes the
//   expected output set into a queue, and an independent monitor pops and
//   compares on the following falling edge. Key points of the directed
//   sequence are also compared immediately against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_if_id_reg;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
    logic        hlt;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_in;
  logic [15:0] instr_in;
  logic        stall;
  logic        flush;
  logic [15:0] instr_out;
  logic [15:0] pc_plus1_out;
  logic        valid_out;
  logic        hlt;
  logic [7:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // Behavioural reference state.
  logic [15:0] m_instr;
  logic [15:0] m_pc1;
  logic        m_valid;
  logic        m_halted;
  logic [7:0]  m_cnt;

  if_id_reg #(
    .NOP_INSTR (16'h0000),
    .HLT_OPCODE(4'hF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .instr_in    (instr_in),
    .stall       (stall),
    .flush       (flush),
    .instr_out   (instr_out),
    .pc_plus1_out(pc_plus1_out),
    .valid_out   (valid_out),
    .hlt         (hlt),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_now(input string tag, input logic [15:0] e_instr, input logic [15:0] e_pc1,
                            input logic e_valid, input logic e_hlt, input logic [7:0] e_cnt);
    check({tag, ".instr"}, instr_out, e_instr);
    check({tag, ".pc1"},   pc_plus1_out, e_pc1);
    check({tag, ".valid"}, {15'd0, valid_out}, {15'd0, e_valid});
    check({tag, ".hlt"},   {15'd0, hlt}, {15'd0, e_hlt});
    check({tag, ".cnt"},   {8'd0, stall_cnt}, {8'd0, e_cnt});
  endtask

  task automatic model_reset();
    m_instr  = 16'h0000;
    m_pc1    = 16'h0000;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_cnt    = 8'h00;
  endtask

  // Apply one rising edge to the model using the current inputs, then queue
  // the resulting expected outputs for the monitor.
  task automatic model_edge();
    exp_t e;
    if (!m_halted && stall && !flush && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    if (flush) begin
      m_instr  = 16'h0000;
      m_valid  = 1'b0;
      m_halted = 1'b0;
    end else if (!m_halted && !stall) begin
      m_instr = instr_in;
      m_pc1   = pc_in + 16'd1;
      m_valid = 1'b1;
      if (instr_in[15:12] == 4'hF) m_halted = 1'b1;
    end
    e.instr = m_instr;
    e.pc1   = m_pc1;
    e.valid = m_valid;
    e.hlt   = m_halted;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  // Drive one vector away from the active edge, then model the edge.
  task automatic drive(input logic [15:0] pc, input logic [15:0] ins, input logic st, input logic fl);
    @(negedge clk);
    pc_in    = pc;
    instr_in = ins;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Monitor: compares registered outputs against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon.instr", instr_out, e.instr);
        check("mon.pc1",   pc_plus1_out, e.pc1);
        check("mon.valid", {15'd0, valid_out}, {15'd0, e.valid});
        check("mon.hlt",   {15'd0, hlt}, {15'd0, e.hlt});
        check("mon.cnt",   {8'd0, stall_cnt}, {8'd0, e.cnt});
      end
    end
  end

  initial begin
    int drain;
    rst_n    = 1'b0;
    pc_in    = 16'h0000;
    instr_in = 16'h0000;
    stall    = 1'b0;
    flush    = 1'b0;
    model_reset();
    #12;
    expect_now("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain capture.
    drive(16'h0004, 16'h1234, 1'b0, 1'b0);
    expect_now("capture", 16'h1234, 16'h0005, 1'b1, 1'b0, 8'h00);

    // Three stalled edges hold the stage.
    for (int i = 0; i < 3; i++) drive(16'h0005, 16'h5678, 1'b1, 1'b0);
    expect_now("stall3", 16'h1234, 16'h0005, 1'b1, 1'b0, 8'h03);

    // Flush wins over stall and the cycle is not counted.
    drive(16'h0006, 16'h5678, 1'b1, 1'b1);
    expect_now("stall_flush", 16'h0000, 16'h0005, 1'b0, 1'b0, 8'h03);

    // HLT capture, halted hold, flush out of HALTED.
    drive(16'h0020, 16'hF000, 1'b0, 1'b0);
    expect_now("hlt_cap", 16'hF000, 16'h0021, 1'b1, 1'b1, 8'h03);
    drive(16'h0021, 16'h2222, 1'b0, 1'b0);
    expect_now("hlt_hold", 16'hF000, 16'h0021, 1'b1, 1'b1, 8'h03);
    drive(16'h0022, 16'h2222, 1'b1, 1'b0);
    expect_now("hlt_nostall", 16'hF000, 16'h0021, 1'b1, 1'b1, 8'h03);
    drive(16'h0023, 16'h2222, 1'b0, 1'b1);
    expect_now("hlt_flush", 16'h0000, 16'h0021, 1'b0, 1'b0, 8'h03);

    // HLT with stall or flush never halts.
    drive(16'h0030, 16'hF123, 1'b1, 1'b0);
    expect_now("hlt_w_stall", 16'h0000, 16'h0021, 1'b0, 1'b0, 8'h04);
    drive(16'h0031, 16'hF456, 1'b0, 1'b1);
    expect_now("hlt_w_flush", 16'h0000, 16'h0021, 1'b0, 1'b0, 8'h04);

    // PC wrap and counter saturation.
    drive(16'hFFFF, 16'h1111, 1'b0, 1'b0);
    expect_now("pc_wrap", 16'h1111, 16'h0000, 1'b1, 1'b0, 8'h04);
    for (int i = 0; i < 300; i++) drive(16'h0000, 16'h4444, 1'b1, 1'b0);
    expect_now("cnt_sat", 16'h1111, 16'h0000, 1'b1, 1'b0, 8'hFF);

    // Asynchronous reset while halted, released before the next edge.
    drive(16'h0040, 16'hF0F0, 1'b0, 1'b0);
    expect_now("hlt_again", 16'hF0F0, 16'h0041, 1'b1, 1'b1, 8'hFF);
    @(negedge clk);
    pc_in    = 16'h0050;
    instr_in = 16'h3333;
    stall    = 1'b0;
    flush    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    expect_now("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
    model_reset();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_edge();
    expect_now("post_rst", 16'h3333, 16'h0051, 1'b1, 1'b0, 8'h00);

    // Let the monitor drain the queue, with a bounded wait.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    check("queue_drain", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
